logic_healthcare_system: RTL and testbench

LOGIC_HEALTHCARE_SYSTEM -- requirements
Module: logic_healthcare_system

---
 rtl/logic_healthcare_pkg.sv | 37 +++
 rtl/lhs_cipher.sv | 18 +
 rtl/logic_healthcare_system.sv | 166 ++++++++++++++++
 tb/tb_logic_healthcare_system.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_healthcare_pkg.sv
// Shared types, abnormality bit positions and clinical thresholds for the
// healthcare snapshot controller.
package logic_healthcare_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_REPORT  = 2'd2
   } lhs_state_t;

   localparam int VEC_PRESSURE = 0;
   localparam int VEC_PH       = 1;
   localparam int VEC_FALL     = 2;
   localparam int VEC_TEMP_HI  = 3;
   localparam int VEC_TEMP_LO  = 4;
   localparam int VEC_RARE     = 5;

   localparam logic [5:0] PRESSURE_LO   = 6'd22;
   localparam logic [5:0] PRESSURE_HI   = 6'd35;
   localparam logic [3:0] PH_LO         = 4'd7;
   localparam logic [3:0] PH_HI         = 4'd8;
   localparam logic [7:0] FALL_DIFF_MAX = 8'd16;
   localparam logic [8:0] TEMP_LO       = 9'd35;
   localparam logic [8:0] TEMP_HI       = 9'd38;
   localparam logic [2:0] RARE_O_NEG    = 3'd0;
   localparam logic [2:0] RARE_AB_NEG   = 3'd6;

   function automatic logic [2:0] popcount6(input logic [5:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 6; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/lhs_cipher.sv
// Lightweight report scrambler: XOR with the key, then split the result into
// a shifted half and a key-offset half.
module lhs_cipher (
   input  logic [7:0] src,
   input  logic [7:0] key,
   output logic [6:0] dataP,
   output logic [6:0] dataQ
);

   logic [7:0] x;
   logic [5:0] offset;

   assign x      = src ^ key;
   assign offset = x[7:2] + key[5:0];
   assign dataP  = x[7:1];
   assign dataQ  = {x[0], offset};

endmodule

// File: rtl/logic_healthcare_system.sv
// Patient snapshot controller: latch vitals on request, flag abnormalities,
// hold the report until confirmed. Define LHS_ENCRYPT_EN to build the cipher.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | waiting for request; inputs latched on request
// ST_CAPTURE | one cycle: flags/cipher computed and registered
// ST_REPORT  | outputs held until confirm clears them
module logic_healthcare_system
   import logic_healthcare_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       request,
   input  logic       confirm,
   input  logic       inputdata,
   input  logic [5:0] pressureData,
   input  logic [3:0] bloodPH,
   input  logic [2:0] bloodType,
   input  logic [7:0] fdSensorValue,
   input  logic [7:0] fdFactoryValue,
   input  logic [7:0] factoryBaseTemp,
   input  logic [3:0] factoryTempCoef,
   input  logic [3:0] tempSensorValue,
   input  logic [7:0] key,
   input  logic [7:0] data,
   output logic [2:0] abnormaliryWarning,
   output logic [5:0] abnormaliryVector,
   output logic [6:0] dataP,
   output logic [6:0] dataQ
);

   lhs_state_t state, state_nxt;

   logic [5:0] lat_pressure;
   logic [3:0] lat_ph;
   logic [2:0] lat_type;
   logic [7:0] lat_fd_sensor;
   logic [7:0] lat_fd_factory;
   logic [7:0] lat_base_temp;
   logic [3:0] lat_temp_coef;
   logic [3:0] lat_temp_sensor;

   logic       capture_en;
   logic       clear_en;
   logic [7:0] fd_diff;
   logic [7:0] temp_prod;
   logic [8:0] temp_c;
   logic [5:0] vec_c;

   assign capture_en = (state == ST_IDLE) && request;
   assign clear_en   = (state == ST_REPORT) && confirm;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (request) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_REPORT;
         ST_REPORT:  if (confirm) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lat_pressure    <= '0;
         lat_ph          <= '0;
         lat_type        <= '0;
         lat_fd_sensor   <= '0;
         lat_fd_factory  <= '0;
         lat_base_temp   <= '0;
         lat_temp_coef   <= '0;
         lat_temp_sensor <= '0;
      end else if (capture_en) begin
         lat_pressure    <= pressureData;
         lat_ph          <= bloodPH;
         lat_type        <= bloodType;
         lat_fd_sensor   <= fdSensorValue;
         lat_fd_factory  <= fdFactoryValue;
         lat_base_temp   <= factoryBaseTemp;
         lat_temp_coef   <= factoryTempCoef;
         lat_temp_sensor <= tempSensorValue;
      end
   end

   // Absolute difference and calibrated temperature are widened so neither wraps.
   assign fd_diff   = (lat_fd_sensor >= lat_fd_factory) ? (lat_fd_sensor - lat_fd_factory)
                                                        : (lat_fd_factory - lat_fd_sensor);
   assign temp_prod = {4'b0000, lat_temp_coef} * {4'b0000, lat_temp_sensor};
   assign temp_c    = {1'b0, lat_base_temp} + {1'b0, temp_prod};

   always_comb begin
      vec_c               = '0;
      vec_c[VEC_PRESSURE] = (lat_pressure < PRESSURE_LO) || (lat_pressure > PRESSURE_HI);
      vec_c[VEC_PH]       = (lat_ph < PH_LO) || (lat_ph > PH_HI);
      vec_c[VEC_FALL]     = fd_diff > FALL_DIFF_MAX;
      vec_c[VEC_TEMP_HI]  = temp_c > TEMP_HI;
      vec_c[VEC_TEMP_LO]  = temp_c < TEMP_LO;
      vec_c[VEC_RARE]     = (lat_type == RARE_O_NEG) || (lat_type == RARE_AB_NEG);
   end

   always_ff @(posedge clock) begin
      if (reset || clear_en) begin
         abnormaliryVector  <= '0;
         abnormaliryWarning <= '0;
      end else if (state == ST_CAPTURE) begin
         abnormaliryVector  <= vec_c;
         abnormaliryWarning <= popcount6(vec_c);
      end
   end

`ifdef LHS_ENCRYPT_EN
   logic       lat_sel;
   logic [7:0] lat_key;
   logic [7:0] lat_data;
   logic [7:0] cipher_src;
   logic [6:0] cipher_p;
   logic [6:0] cipher_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         lat_sel  <= 1'b0;
         lat_key  <= '0;
         lat_data <= '0;
      end else if (capture_en) begin
         lat_sel  <= inputdata;
         lat_key  <= key;
         lat_data <= data;
      end
   end

   // In record mode the cipher consumes the vector being registered this cycle.
   assign cipher_src = lat_sel ? lat_data : {2'b00, vec_c};

   lhs_cipher u_cipher (
      .src   (cipher_src),
      .key   (lat_key),
      .dataP (cipher_p),
      .dataQ (cipher_q)
   );

   always_ff @(posedge clock) begin
      if (reset || clear_en) begin
         dataP <= '0;
         dataQ <= '0;
      end else if (state == ST_CAPTURE) begin
         dataP <= cipher_p;
         dataQ <= cipher_q;
      end
   end
`else
   logic unused_cipher_in;
   assign unused_cipher_in = ^{key, data, inputdata};
   assign dataP = '0;
   assign dataQ = '0;
`endif

endmodule

// File: tb/tb_logic_healthcare_system.sv
// Scoreboard bench for logic_healthcare_system: stimulus queues expected
// snapshots tagged with a due cycle; a negedge monitor pops and compares.
module tb_logic_healthcare_system;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       request = 1'b0;
   logic       confirm = 1'b0;
   logic       inputdata = 1'b0;
   logic [5:0] pressureData = '0;
   logic [3:0] bloodPH = '0;
   logic [2:0] bloodType = '0;
   logic [7:0] fdSensorValue = '0;
   logic [7:0] fdFactoryValue = '0;
   logic [7:0] factoryBaseTemp = '0;
   logic [3:0] factoryTempCoef = '0;
   logic [3:0] tempSensorValue = '0;
   logic [7:0] key = '0;
   logic [7:0] data = '0;
   logic [2:0] abnormaliryWarning;
   logic [5:0] abnormaliryVector;
   logic [6:0] dataP;
   logic [6:0] dataQ;

   logic_healthcare_system dut (
      .clock              (clock),
      .reset              (reset),
      .request            (request),
      .confirm            (confirm),
      .inputdata          (inputdata),
      .pressureData       (pressureData),
      .bloodPH            (bloodPH),
      .bloodType          (bloodType),
      .fdSensorValue      (fdSensorValue),
      .fdFactoryValue     (fdFactoryValue),
      .factoryBaseTemp    (factoryBaseTemp),
      .factoryTempCoef    (factoryTempCoef),
      .tempSensorValue    (tempSensorValue),
      .key                (key),
      .data               (data),
      .abnormaliryWarning (abnormaliryWarning),
      .abnormaliryVector  (abnormaliryVector),
      .dataP              (dataP),
      .dataQ              (dataQ)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      string      name;
      int         due;
      logic [5:0] vec;
      logic [2:0] warn;
      logic [6:0] p;
      logic [6:0] q;
   } exp_t;

   typedef struct {
      logic [5:0] pressure;
      logic [3:0] ph;
      logic [2:0] btype;
      logic [7:0] fd_s;
      logic [7:0] fd_f;
      logic [7:0] base;
      logic [3:0] coef;
      logic [3:0] tsens;
      logic       sel;
      logic [7:0] k;
      logic [7:0] d;
   } stim_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   task automatic push(input string nm, input int due, input logic [5:0] v, input logic [2:0] w,
                       input logic [6:0] p, input logic [6:0] q);
      exp_t e;
      e.name = nm; e.due = due; e.vec = v; e.warn = w; e.p = p; e.q = q;
      sb.push_back(e);
   endtask

   task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, fld, act, exp, cyc);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
               checks++;
               fails++;
               $display("FAIL %s: sample missed, due cycle %0d, now %0d", e.name, e.due, cyc);
            end else begin
               cmp(e.name, "vector",  {2'b00, abnormaliryVector}, {2'b00, e.vec});
               cmp(e.name, "warning", {5'b0, abnormaliryWarning}, {5'b0, e.warn});
               cmp(e.name, "dataP",   {1'b0, dataP}, {1'b0, e.p});
               cmp(e.name, "dataQ",   {1'b0, dataQ}, {1'b0, e.q});
            end
         end
      end
   end

   function automatic stim_t mk(input logic [5:0] pr, input logic [3:0] ph, input logic [2:0] bt,
                                input logic [7:0] fs, input logic [7:0] ff, input logic [7:0] bs,
                                input logic [3:0] cf, input logic [3:0] ts, input logic sl,
                                input logic [7:0] k, input logic [7:0] d);
      stim_t s;
      s.pressure = pr; s.ph = ph; s.btype = bt; s.fd_s = fs; s.fd_f = ff; s.base = bs;
      s.coef = cf; s.tsens = ts; s.sel = sl; s.k = k; s.d = d;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      pressureData = s.pressure; bloodPH = s.ph; bloodType = s.btype;
      fdSensorValue = s.fd_s; fdFactoryValue = s.fd_f;
      factoryBaseTemp = s.base; factoryTempCoef = s.coef; tempSensorValue = s.tsens;
      inputdata = s.sel; key = s.k; data = s.d;
   endtask

   // Full request/report/confirm round trip for one directed vector.
   task automatic run_vec(input string nm, input stim_t s, input logic [5:0] ev, input logic [2:0] ew,
                          input logic [6:0] ep, input logic [6:0] eq,
                          input bit conf_early, input bit req_in_report);
      logic [6:0] xp, xq;
`ifdef LHS_ENCRYPT_EN
      xp = ep; xq = eq;
`else
      xp = '0; xq = '0;
`endif
      @(negedge clock);
      drive(s);
      request = 1'b1;
      confirm = conf_early;
      push(nm, cyc + 2, ev, ew, xp, xq);
      push({nm, "_hold"}, cyc + 3, ev, ew, xp, xq);
      @(negedge clock);
      request = 1'b0;
      @(negedge clock);
      confirm = 1'b0;
      @(negedge clock);
      if (req_in_report) begin
         drive(mk(6'd10, 4'd2, 3'd0, 8'd255, 8'd0, 8'd200, 4'd0, 4'd0, 1'b1, 8'h33, 8'h5A));
         request = 1'b1;
         push({nm, "_req_in_report"}, cyc + 1, ev, ew, xp, xq);
         push({nm, "_req_in_report2"}, cyc + 2, ev, ew, xp, xq);
         @(negedge clock);
         request = 1'b0;
         @(negedge clock);
      end
      confirm = 1'b1;
      push({nm, "_confirm"}, cyc + 1, 6'd0, 3'd0, 7'd0, 7'd0);
      @(negedge clock);
      confirm = 1'b0;
      push({nm, "_idle"}, cyc + 1, 6'd0, 3'd0, 7'd0, 7'd0);
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      push("reset", 2, 6'd0, 3'd0, 7'd0, 7'd0);
      repeat (3) @(negedge clock);
      reset = 1'b0;

      run_vec("normal", mk(6'd30, 4'd7, 3'd3, 8'd100, 8'd100, 8'd30, 4'd1, 4'd6, 1'b1, 8'h0F, 8'hA5),
              6'h00, 3'd0, 7'h55, 7'h39, 1'b1, 1'b1);
      run_vec("all_abnormal", mk(6'd10, 4'd3, 3'd6, 8'd200, 8'd100, 8'd40, 4'd0, 4'd5, 1'b0, 8'h01, 8'h00),
              6'h2F, 3'd5, 7'h17, 7'h0C, 1'b0, 1'b0);
      run_vec("bound_low", mk(6'd22, 4'd8, 3'd1, 8'd116, 8'd100, 8'd35, 4'd0, 4'd9, 1'b0, 8'h00, 8'h00),
              6'h00, 3'd0, 7'h00, 7'h00, 1'b0, 1'b0);
      run_vec("bound_high", mk(6'd35, 4'd7, 3'd7, 8'd100, 8'd116, 8'd30, 4'd2, 4'd4, 1'b1, 8'h00, 8'h00),
              6'h00, 3'd0, 7'h00, 7'h00, 1'b0, 1'b0);
      run_vec("temp_nowrap", mk(6'd21, 4'd8, 3'd0, 8'd0, 8'd255, 8'd255, 4'd15, 4'd15, 1'b0, 8'hF0, 8'h55),
              6'h2D, 3'd4, 7'h6E, 7'h67, 1'b0, 1'b0);
      run_vec("temp_low", mk(6'd36, 4'd8, 3'd2, 8'd50, 8'd60, 8'd34, 4'd0, 4'd3, 1'b1, 8'hC3, 8'h3C),
              6'h11, 3'd2, 7'h7F, 7'h42, 1'b0, 1'b0);

      // Reset while in CAPTURE must abort the snapshot.
      @(negedge clock);
      drive(mk(6'd10, 4'd3, 3'd6, 8'd200, 8'd100, 8'd40, 4'd0, 4'd5, 1'b0, 8'h01, 8'h00));
      request = 1'b1;
      push("reset_in_capture", cyc + 2, 6'd0, 3'd0, 7'd0, 7'd0);
      push("reset_in_capture_after", cyc + 3, 6'd0, 3'd0, 7'd0, 7'd0);
      @(negedge clock);
      request = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      run_vec("after_reset", mk(6'd10, 4'd3, 3'd6, 8'd200, 8'd100, 8'd40, 4'd0, 4'd5, 1'b0, 8'h01, 8'h00),
              6'h2F, 3'd5, 7'h17, 7'h0C, 1'b0, 1'b0);

      repeat (3) @(negedge clock);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         fails++;
         $display("FAIL %s: never sampled, due cycle %0d, now %0d", e.name, e.due, cyc);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
